cycle_sequencer: RTL and testbench
==================================

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous reset, active-high.
REQ-003 SHALL have port run, input, 1 bit: level; while high, instructions execute back-to-back.
REQ-004 SHALL have port done, input, 1 bit: OR of all instruction-decoder done terms; sampled only in CK phase.
REQ-005 SHALL have ports ck1..ck6, output, 1 bit each: step clock-phase windows.
REQ-006 SHALL have ports stb1..stb6, output, 1 bit each: step strobe windows.
REQ-007 SHALL have port cycleStart, output, 1 bit: high exactly when ck1 is high.
REQ-008 SHALL have port overrun, output, 1 bit: sticky flag, set when step 6 strobe ends without done.
REQ-009 SHALL have port stepReq, input, 1 bit, present only with SEQ_SINGLESTEP_EN: single-instruction request.

Function
REQ-010 SHALL implement states IDLE, CK, STB, plus a step counter with range 1..6.
REQ-011 SHALL drive all ck/stb outputs low in IDLE.
REQ-012 SHALL drive exactly one output high in CK (ckN) or STB (stbN), N = step; all outputs SHALL be registered and one-hot or zero.
REQ-013 IDLE with run=1: SHALL go to CK, step=1, on the next edge.
REQ-014 CK, done=0: SHALL go to STB with the same step.
REQ-015 CK, done=1: SHALL go to CK step=1 if run=1, else to IDLE; stbN SHALL NOT be issued.
REQ-016 STB with step<6: SHALL go to CK with step+1.
REQ-017 STB with step=6: SHALL set overrun, then go to CK step=1 if run=1, else to IDLE.
REQ-018 SHALL ignore done in STB and IDLE.
REQ-019 run deasserted mid-instruction: the current instruction SHALL complete (done or overrun) before entering IDLE; run SHALL be sampled only at the instruction boundary.
REQ-020 Latency: ck1 SHALL rise 1 clk after run is first sampled high in IDLE; each ck/stb window SHALL last exactly 1 clk.
REQ-021 A done in ckN SHALL be followed by ck1 on the very next clk, with no gap cycle, when run=1.
REQ-022 overrun SHALL be cleared only by reset.

Reset
REQ-023 reset=1 SHALL immediately force IDLE, step=1, all ck/stb low, cycleStart=0, overrun=0, independent of clk.
REQ-024 Reset asserted mid-instruction SHALL abort the instruction; after release, ck1 SHALL appear only once run is sampled high.

Configuration
REQ-025 Macro SEQ_SINGLESTEP_EN, when defined, SHALL add stepReq and an internal registered edge detector.
REQ-026 With the macro, in IDLE with run=0, a stepReq rising edge SHALL start exactly one instruction from ck1, then return to IDLE. stepReq SHALL be ignored outside IDLE, and a level held high SHALL NOT retrigger.
REQ-027 Without the macro, stepReq SHALL be absent and behaviour SHALL be exactly REQ-010..REQ-024.

Verification
REQ-028 reset, then run=1, done pulsed in ck2 -> sequence ck1, stb1, ck2, then ck1 on the next clk; overrun=0.
REQ-029 run=1, done never asserted -> ck1, stb1 ... ck6, stb6 (12 clks), then overrun=1 and ck1 on the next clk.
REQ-030 run dropped during stb1, done in ck4 -> ck2, stb2, ck3, stb3, ck4, then IDLE with all outputs 0.
REQ-031 reset asserted asynchronously during stb3 -> all outputs 0 before the next clk edge; overrun=0.
REQ-032 done held high through STB cycles -> ignored in STB; acted on only in the following CK.
REQ-033 SEQ_SINGLESTEP_EN, run=0, stepReq held high 20 clks with done in ck3 -> exactly one ck1..ck3 pass, then IDLE.

Source files
------------

// File: rtl/cycle_sequencer_if.sv
// cycle_sequencer_if
//
// Purpose: bundles the sequencer's control and phase-window signals so the
// sequencer and the instruction decoder can be connected as one port.
//
// Signals:
//   run        - level from the control side; keep executing instructions
//   done       - OR of all instruction-decoder done terms
//   ck1..ck6   - one-cycle clock-phase window for steps 1..6
//   stb1..stb6 - one-cycle strobe window for steps 1..6
//   cycleStart - marks the first phase of every instruction (same as ck1)
//   overrun    - sticky: an instruction ran past step 6 without done
//   stepReq    - single-instruction request (only with SEQ_SINGLESTEP_EN)
//
// Modports:
//   master - the sequencer side (drives the windows and flags)
//   slave  - the decoder/control side (drives run, done, stepReq)
//
// Configuration macro: SEQ_SINGLESTEP_EN adds the stepReq signal.

interface cycle_sequencer_if;

   logic run;
   logic done;
   logic ck1, ck2, ck3, ck4, ck5, ck6;
   logic stb1, stb2, stb3, stb4, stb5, stb6;
   logic cycleStart;
   logic overrun;
`ifdef SEQ_SINGLESTEP_EN
   logic stepReq;
`endif

`ifdef SEQ_SINGLESTEP_EN
   modport master (
      input  run, done, stepReq,
      output ck1, ck2, ck3, ck4, ck5, ck6,
      output stb1, stb2, stb3, stb4, stb5, stb6,
      output cycleStart, overrun
   );

   modport slave (
      output run, done, stepReq,
      input  ck1, ck2, ck3, ck4, ck5, ck6,
      input  stb1, stb2, stb3, stb4, stb5, stb6,
      input  cycleStart, overrun
   );
`else
   modport master (
      input  run, done,
      output ck1, ck2, ck3, ck4, ck5, ck6,
      output stb1, stb2, stb3, stb4, stb5, stb6,
      output cycleStart, overrun
   );

   modport slave (
      output run, done,
      input  ck1, ck2, ck3, ck4, ck5, ck6,
      input  stb1, stb2, stb3, stb4, stb5, stb6,
      input  cycleStart, overrun
   );
`endif

endinterface

// File: rtl/cycle_sequencer.sv
// cycle_sequencer
//
// Purpose: steps an instruction through up to six clock-phase/strobe window
// pairs (ck1, stb1, ck2, stb2 ... ck6, stb6). Each window lasts one clock.
// A done seen during a ck window ends the instruction right away (the
// matching strobe is skipped); running off the end of stb6 without done
// raises the sticky overrun flag. The run level is only looked at between
// instructions, so an instruction in flight always completes.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high; returns to IDLE and clears overrun
//   bus   - cycle_sequencer_if.master (run, done, ck1..ck6, stb1..stb6,
//           cycleStart, overrun, and stepReq when enabled)
//
// Configuration macro: SEQ_SINGLESTEP_EN
//   When defined, a rising edge on bus.stepReq while IDLE with run low runs
//   exactly one instruction. The edge detector is registered so a level held
//   high never retriggers, and edges outside IDLE are dropped.

module cycle_sequencer (
   input logic           clk,
   input logic           reset,
   cycle_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CK   = 2'd1,
      STB  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_nextState;
   logic [2:0] r_step;
   logic [2:0] w_nextStep;
   logic [5:0] r_ck;
   logic [5:0] r_stb;
   logic [5:0] w_nextCk;
   logic [5:0] w_nextStb;
   logic       r_overrun;
   logic       w_setOverrun;
   logic       w_start;

`ifdef SEQ_SINGLESTEP_EN
   logic r_stepReqD;
   logic w_stepRise;

   // Remember last cycle's stepReq so only a 0->1 transition counts as a
   // request. It samples every cycle, so an edge that lands while an
   // instruction is running is consumed and lost rather than queued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stepReqD <= 1'b0;
      end else begin
         r_stepReqD <= bus.stepReq;
      end
   end

   // An instruction starts from IDLE on run or on a fresh step request.
   // After that one instruction the boundary decision only looks at run,
   // which is what returns a single step to IDLE.
   always_comb begin
      w_stepRise = bus.stepReq & ~r_stepReqD;
      w_start    = bus.run | w_stepRise;
   end
`else
   // Without single-step support only run can start an instruction.
   always_comb begin
      w_start = bus.run;
   end
`endif

   // Next-state logic. done is only meaningful during a ck window; in STB
   // and IDLE it is deliberately not looked at. run is only consulted at
   // an instruction boundary (done in CK, or the end of stb6).
   always_comb begin
      w_nextState  = r_state;
      w_nextStep   = r_step;
      w_setOverrun = 1'b0;
      case (r_state)
         IDLE: begin
            w_nextStep = 3'd1;
            if (w_start) begin
               w_nextState = CK;
            end
         end
         CK: begin
            if (bus.done) begin
               w_nextStep  = 3'd1;
               w_nextState = bus.run ? CK : IDLE;
            end else begin
               w_nextState = STB;
            end
         end
         STB: begin
            if (r_step >= 3'd6) begin
               w_setOverrun = 1'b1;
               w_nextStep   = 3'd1;
               w_nextState  = bus.run ? CK : IDLE;
            end else begin
               w_nextStep  = r_step + 3'd1;
               w_nextState = CK;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextStep  = 3'd1;
         end
      endcase
   end

   // Decode the upcoming state/step into one-hot window vectors so the
   // outputs can be taken straight from flops and never glitch. At most one
   // bit across both vectors is ever set.
   always_comb begin
      w_nextCk  = '0;
      w_nextStb = '0;
      for (int i = 0; i < 6; i++) begin
         if (w_nextStep == 3'(i + 1)) begin
            w_nextCk[i]  = (w_nextState == CK);
            w_nextStb[i] = (w_nextState == STB);
         end
      end
   end

   // State, step and the registered window outputs. Reset is asynchronous,
   // so every window and the overrun flag drop the moment reset rises.
   // overrun only ever gets set here; nothing but reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_step    <= 3'd1;
         r_ck      <= '0;
         r_stb     <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_step    <= w_nextStep;
         r_ck      <= w_nextCk;
         r_stb     <= w_nextStb;
         r_overrun <= r_overrun | w_setOverrun;
      end
   end

   // Fan the registered vectors out to the named interface signals.
   // cycleStart is the same flop as ck1.
   assign bus.ck1        = r_ck[0];
   assign bus.ck2        = r_ck[1];
   assign bus.ck3        = r_ck[2];
   assign bus.ck4        = r_ck[3];
   assign bus.ck5        = r_ck[4];
   assign bus.ck6        = r_ck[5];
   assign bus.stb1       = r_stb[0];
   assign bus.stb2       = r_stb[1];
   assign bus.stb3       = r_stb[2];
   assign bus.stb4       = r_stb[3];
   assign bus.stb5       = r_stb[4];
   assign bus.stb6       = r_stb[5];
   assign bus.cycleStart = r_ck[0];
   assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer
//
// Purpose: self-checking bench for cycle_sequencer. A behavioural model
// tracks the position inside an instruction as a single phase number
// (0 = idle, 1..12 = ck1, stb1, ck2 ... stb6) and a compare process checks
// every window, cycleStart and overrun against it on every falling edge.
// Directed sequences also check hand-computed literal windows.
//
// Configuration macro: SEQ_SINGLESTEP_EN (adds the single-step sequence).

module tb_cycle_sequencer;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   mPos;
   bit   mOvr;
   bit   mPrevStep;

   cycle_sequencer_if bus ();

   cycle_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // Free-running 10-unit clock; rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Window vector in the order {stb6..stb1, ck6..ck1}.
   function automatic logic [11:0] dutVec();
      return {bus.stb6, bus.stb5, bus.stb4, bus.stb3, bus.stb2, bus.stb1,
              bus.ck6, bus.ck5, bus.ck4, bus.ck3, bus.ck2, bus.ck1};
   endfunction

   function automatic logic [11:0] fCk(input int n);
      logic [11:0] v;
      v = 12'd1;
      return v << (n - 1);
   endfunction

   function automatic logic [11:0] fStb(input int n);
      logic [11:0] v;
      v = 12'd1;
      return v << (n + 5);
   endfunction

   // Phase p: odd p is ck((p+1)/2), even p is stb(p/2), zero is idle.
   function automatic logic [11:0] phaseVec(input int p);
      logic [11:0] v;
      v = '0;
      if (p > 0) begin
         if (p % 2 == 1) v = fCk((p + 1) / 2);
         else            v = fStb(p / 2);
      end
      return v;
   endfunction

   // Behavioural model: an instruction is just a walk through phases 1..12.
   // done in a ck phase, or falling off phase 12, ends it; the next phase
   // is then 1 if run is high, otherwise idle.
   always @(posedge clk or posedge reset) begin
      bit startReq;
      bit stepNow;
      if (reset) begin
         mPos      = 0;
         mOvr      = 1'b0;
         mPrevStep = 1'b0;
      end else begin
         stepNow = 1'b0;
`ifdef SEQ_SINGLESTEP_EN
         stepNow = bus.stepReq;
`endif
         startReq  = bus.run || (stepNow && !mPrevStep);
         mPrevStep = stepNow;
         if (mPos == 0) begin
            if (startReq) mPos = 1;
         end else if (mPos % 2 == 1) begin
            if (bus.done) mPos = bus.run ? 1 : 0;
            else          mPos = mPos + 1;
         end else if (mPos == 12) begin
            mOvr = 1'b1;
            mPos = bus.run ? 1 : 0;
         end else begin
            mPos = mPos + 1;
         end
      end
   end

   // Continuous comparison against the model on every falling edge.
   always @(negedge clk) begin
      logic [13:0] got;
      logic [13:0] exp;
      got = {bus.overrun, bus.cycleStart, dutVec()};
      exp = {mOvr, (mPos == 1), phaseVec(mPos)};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL model t=%0t: got ovr/cs/win %h, expected %h", $time, got, exp);
      end
   end

   // Drive run/done for the next rising edge, then return 2 units after
   // it with the outputs of that edge settled.
   task automatic applyStimulus(input logic r, input logic d);
      bus.run  = r;
      bus.done = d;
      @(posedge clk);
      #2;
   endtask

   // Literal check of the windows, overrun, and cycleStart == ck1.
   task automatic checkOutput(input string name, input logic [11:0] expVec, input logic expOvr);
      logic [13:0] got;
      logic [13:0] exp;
      got = {bus.overrun, bus.cycleStart, dutVec()};
      exp = {expOvr, expVec[0], expVec};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got ovr/cs/win %h, expected %h", name, got, exp);
      end
   endtask

   initial begin
      int ck1Count;
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      bus.run  = 1'b0;
      bus.done = 1'b0;
`ifdef SEQ_SINGLESTEP_EN
      bus.stepReq = 1'b0;
`endif

      // Reset state, then release with run low.
      @(posedge clk);
      #2;
      checkOutput("reset_state", 12'h000, 1'b0);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle_after_reset", 12'h000, 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("done_ignored_idle", 12'h000, 1'b0);

      // run high, done in ck2: ck1, stb1, ck2, then straight back to ck1.
      $display("[TB] sequence: done in ck2");
      applyStimulus(1'b1, 1'b0);
      checkOutput("d2_ck1", fCk(1), 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("d2_stb1", fStb(1), 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("d2_ck2", fCk(2), 1'b0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("d2_ck1_again", fCk(1), 1'b0);

      // No done at all: all twelve windows, then overrun and ck1.
      $display("[TB] sequence: overrun");
      applyStimulus(1'b1, 1'b0);
      checkOutput("ov_stb1", fStb(1), 1'b0);
      for (int k = 2; k <= 6; k++) begin
         applyStimulus(1'b1, 1'b0);
         checkOutput($sformatf("ov_ck%0d", k), fCk(k), 1'b0);
         applyStimulus(1'b1, 1'b0);
         checkOutput($sformatf("ov_stb%0d", k), fStb(k), 1'b0);
      end
      applyStimulus(1'b1, 1'b0);
      checkOutput("ov_ck1_set", fCk(1), 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("ov_sticky_stb1", fStb(1), 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("ov_done_in_stb", fCk(2), 1'b1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("ov_idle_sticky", 12'h000, 1'b1);

      // Asynchronous reset clears overrun without waiting for a clock.
      reset = 1'b1;
      #1;
      checkOutput("ov_async_clear", 12'h000, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // run dropped during stb1, done in ck4: instruction finishes, then idle.
      $display("[TB] sequence: run dropped mid-instruction");
      applyStimulus(1'b1, 1'b0);
      checkOutput("rd_ck1", fCk(1), 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("rd_stb1", fStb(1), 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("rd_ck2", fCk(2), 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("rd_stb2", fStb(2), 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("rd_ck3", fCk(3), 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("rd_stb3", fStb(3), 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("rd_ck4", fCk(4), 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("rd_idle", 12'h000, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("rd_stay_idle", 12'h000, 1'b0);

      // done held high through a strobe: ignored there, honoured in ck2.
      $display("[TB] sequence: done held through strobe");
      applyStimulus(1'b1, 1'b0);
      checkOutput("dh_ck1", fCk(1), 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("dh_stb1", fStb(1), 1'b0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("dh_ck2_stb_ignored", fCk(2), 1'b0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("dh_ck1_after_done", fCk(1), 1'b0);

      // Continue to stb3, then reset asynchronously in the middle of it.
      $display("[TB] sequence: reset during stb3");
      applyStimulus(1'b0, 1'b0);
      checkOutput("rs_stb1", fStb(1), 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("rs_ck3", fCk(3), 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("rs_stb3", fStb(3), 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("rs_async_zero", 12'h000, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0);
      checkOutput("rs_idle_no_run", 12'h000, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("rs_ck1_on_run", fCk(1), 1'b0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("rs_idle_end", 12'h000, 1'b0);

`ifdef SEQ_SINGLESTEP_EN
      // stepReq held for 20 clocks with run low: one pass ck1..ck3, then idle.
      $display("[TB] sequence: single step");
      ck1Count    = 0;
      bus.stepReq = 1'b1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, (i == 5));
         if (bus.ck1) ck1Count++;
         if (i == 4) checkOutput("ss_ck3", fCk(3), 1'b0);
         if (i == 5) checkOutput("ss_idle", 12'h000, 1'b0);
      end
      checkOutput("ss_idle_held", 12'h000, 1'b0);
      checks++;
      if (ck1Count != 1) begin
         errors++;
         $display("[TB] FAIL ss_ck1_count: got %0d, expected 1", ck1Count);
      end
      bus.stepReq = 1'b0;
      applyStimulus(1'b0, 1'b0);
`else
      ck1Count = 0;
`endif

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
